// File: rtl/ct_pkt_demux_pkg.sv
// Shared types and the flow-table lookup for the packet demultiplexer.
// The lookup works on fixed maximum widths so one function serves every parameterisation.
package ct_pkt_demux_pkg;

  localparam int CT_MAX_NO   = 32;
  localparam int CT_MAX_FW   = 32;
  localparam int CT_MAX_BITS = 1024;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } ct_state_e;

  // Lowest matching table entry wins; no match yields an all-zero mask.
  function automatic logic [CT_MAX_NO-1:0] ct_flow_lookup(
    input logic [CT_MAX_FW-1:0]   flow,
    input logic [CT_MAX_BITS-1:0] flows,
    input logic [CT_MAX_BITS-1:0] enables,
    input int                     nf,
    input int                     no,
    input int                     wf
  );
    logic [CT_MAX_FW-1:0]   fmask;
    logic [CT_MAX_FW-1:0]   fk;
    logic [CT_MAX_NO-1:0]   omask;
    logic [CT_MAX_NO-1:0]   mask;
    logic [CT_MAX_BITS-1:0] sh_f;
    logic [CT_MAX_BITS-1:0] sh_e;
    logic                   found;
    fmask = (CT_MAX_FW'(1) << wf) - CT_MAX_FW'(1);
    omask = (CT_MAX_NO'(1) << no) - CT_MAX_NO'(1);
    mask  = '0;
    found = 1'b0;
    for (int k = 0; k < nf; k++) begin
      sh_f = flows >> (k * wf);
      sh_e = enables >> (k * no);
      fk   = sh_f[CT_MAX_FW-1:0] & fmask;
      if (!found && (fk == (flow & fmask))) begin
        mask  = sh_e[CT_MAX_NO-1:0] & omask;
        found = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/ct_pkt_demux_if.sv
// Merged input stream plus the NO fanned-out output streams of the packet demultiplexer.
interface ct_pkt_demux_if #(
  parameter int NO = 2,
  parameter int WD = 16,
  parameter int WF = 2
);
  logic [WD-1:0]    i_data;
  logic [WF-1:0]    i_flow_id;
  logic             i_eop;
  logic             i_valid;
  logic             o_ready;
  logic [NO*WD-1:0] o_data;
  logic [NO*WF-1:0] o_flow_id;
  logic [NO-1:0]    o_eop;
  logic [NO-1:0]    o_valid;
  logic [NO-1:0]    i_ready;
  logic             o_drop;

  modport slave (
    input  i_data, i_flow_id, i_eop, i_valid, i_ready,
    output o_ready, o_data, o_flow_id, o_eop, o_valid, o_drop
  );

  modport master (
    output i_data, i_flow_id, i_eop, i_valid, i_ready,
    input  o_ready, o_data, o_flow_id, o_eop, o_valid, o_drop
  );
endinterface

// File: rtl/ct_pkt_demux_slot.sv
// One-entry output register: load wins over drain, so a beat can enter while the old one leaves.
module ct_pkt_demux_slot #(
  parameter int WD = 16,
  parameter int WF = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          ready_i,
  input  logic [WD-1:0] data_i,
  input  logic [WF-1:0] flow_i,
  input  logic          eop_i,
  output logic          valid_o,
  output logic [WD-1:0] data_o,
  output logic [WF-1:0] flow_o,
  output logic          eop_o
);

  logic          valid_q, valid_d;
  logic [WD-1:0] data_q;
  logic [WF-1:0] flow_q;
  logic          eop_q;

  always_comb begin
    valid_d = valid_q;
    if (load_i) begin
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
      flow_q <= flow_i;
      eop_q  <= eop_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign flow_o  = flow_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/ct_pkt_demux.sv
// Packet-aware demultiplexer: routes each packet to the output set chosen on its first beat
// and keeps that set until EOP, so packets never interleave; multicast loads all targets at once.
module ct_pkt_demux
  import ct_pkt_demux_pkg::*;
#(
  parameter int                NO      = 2,
  parameter int                WD      = 16,
  parameter int                WF      = 2,
  parameter int                NF      = 2,
  parameter logic [NF*WF-1:0]  FLOWS   = '0,
  parameter logic [NF*NO-1:0]  ENABLES = '0
) (
  input logic           clk,
  input logic           reset,
  ct_pkt_demux_if.slave bus
);

  ct_state_e            state_q, state_d;
  logic [NO-1:0]        mask_q, mask_d;
  logic [WF-1:0]        flow_q, flow_d;
  logic [CT_MAX_NO-1:0] lookup_full;
  logic                 unused_lookup;
  logic [NO-1:0]        lookup;
  logic [NO-1:0]        active;
  logic [NO-1:0]        slot_free;
  logic [NO-1:0]        load;
  logic [WF-1:0]        ld_flow;
  logic                 acc;
  logic                 in_idle;

  logic [NO-1:0][WD-1:0] data_arr;
  logic [NO-1:0][WF-1:0] flow_arr;
  logic [NO-1:0]         eop_arr;
  logic [NO-1:0]         vld_arr;

  assign lookup_full = ct_flow_lookup(CT_MAX_FW'(bus.i_flow_id), CT_MAX_BITS'(FLOWS),
                                      CT_MAX_BITS'(ENABLES), NF, NO, WF);
  assign lookup        = lookup_full[NO-1:0];
  assign unused_lookup = ^lookup_full;

  assign in_idle   = (state_q == ST_IDLE);
  assign active    = in_idle ? lookup : mask_q;
  assign slot_free = ~vld_arr | bus.i_ready;

  // Ready depends only on slots in the active mask; i_valid never feeds back into it.
  assign bus.o_ready = !reset && (&(slot_free | ~active));
  assign acc         = bus.i_valid && bus.o_ready;
  assign load        = {NO{acc}} & active;
  assign ld_flow     = in_idle ? bus.i_flow_id : flow_q;
  assign bus.o_drop  = acc && in_idle && (lookup == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    flow_q <= flow_d;
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    flow_d  = flow_q;
    if (acc) begin
      if (in_idle && !bus.i_eop) begin
        state_d = ST_PKT;
        mask_d  = lookup;
        flow_d  = bus.i_flow_id;
      end else if (!in_idle && bus.i_eop) begin
        state_d = ST_IDLE;
      end
    end
  end

  for (genvar j = 0; j < NO; j++) begin : g_slot
    ct_pkt_demux_slot #(
      .WD (WD),
      .WF (WF)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load[j]),
      .ready_i (bus.i_ready[j]),
      .data_i  (bus.i_data),
      .flow_i  (ld_flow),
      .eop_i   (bus.i_eop),
      .valid_o (vld_arr[j]),
      .data_o  (data_arr[j]),
      .flow_o  (flow_arr[j]),
      .eop_o   (eop_arr[j])
    );
  end

  assign bus.o_valid   = vld_arr;
  assign bus.o_data    = data_arr;
  assign bus.o_flow_id = flow_arr;
  assign bus.o_eop     = eop_arr;

endmodule

// File: tb/tb_ct_pkt_demux.sv
// Bench for ct_pkt_demux: directed scenarios plus randomized traffic against a per-port queue model.
module tb_ct_pkt_demux;
  localparam int NO = 2;
  localparam int WD = 16;
  localparam int WF = 2;
  localparam int NF = 2;
  localparam logic [3:0] FLOWS = {2'd2, 2'd0};
  localparam logic [3:0] EN_A  = {2'b10, 2'b01};
  localparam logic [3:0] EN_B  = {2'b11, 2'b01};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ct_pkt_demux_if #(.NO(NO), .WD(WD), .WF(WF)) bus_a ();
  ct_pkt_demux_if #(.NO(NO), .WD(WD), .WF(WF)) bus_b ();

  ct_pkt_demux #(.NO(NO), .WD(WD), .WF(WF), .NF(NF), .FLOWS(FLOWS), .ENABLES(EN_A))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  ct_pkt_demux #(.NO(NO), .WD(WD), .WF(WF), .NF(NF), .FLOWS(FLOWS), .ENABLES(EN_B))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;

  // Reference state for dut_a: one pending beat per port plus the current packet's route.
  logic        m_vld  [2];
  logic [15:0] m_data [2];
  logic [1:0]  m_flow [2];
  logic        m_eop  [2];
  logic        m_inpkt;
  logic [1:0]  m_mask;
  logic [1:0]  m_flowl;

  function automatic logic [1:0] tb_lookup(input logic [1:0] f);
    int          tflow [2] = '{0, 2};
    logic [1:0]  ten   [2] = '{2'b01, 2'b10};
    for (int k = 0; k < 2; k++) if (tflow[k] == int'(f)) return ten[k];
    return 2'b00;
  endfunction

  function automatic logic exp_ready();
    logic [1:0] r;
    if (reset) return 1'b0;
    r = m_inpkt ? m_mask : tb_lookup(bus_a.i_flow_id);
    for (int j = 0; j < 2; j++) if (r[j] && m_vld[j] && !bus_a.i_ready[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_drop();
    return bus_a.i_valid && exp_ready() && !m_inpkt && (tb_lookup(bus_a.i_flow_id) == 2'b00);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) m_vld[j] = 1'b0;
    m_inpkt = 1'b0;
    m_mask  = 2'b00;
    m_flowl = 2'b00;
  endtask

  task automatic drive_a(input logic v, input logic [1:0] f, input logic e,
                         input logic [15:0] d, input logic [1:0] r);
    bus_a.i_valid = v; bus_a.i_flow_id = f; bus_a.i_eop = e; bus_a.i_data = d; bus_a.i_ready = r;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] f, input logic e,
                         input logic [15:0] d, input logic [1:0] r);
    bus_b.i_valid = v; bus_b.i_flow_id = f; bus_b.i_eop = e; bus_b.i_data = d; bus_b.i_ready = r;
  endtask

  // Advance one clock, updating the model from the inputs dut_a sees at the edge.
  task automatic step();
    logic [1:0]  r, rdy, fin, fl;
    logic        acc, e, rs;
    logic [15:0] d;
    rs  = reset;
    r   = m_inpkt ? m_mask : tb_lookup(bus_a.i_flow_id);
    acc = bus_a.i_valid && exp_ready();
    fin = bus_a.i_flow_id;
    fl  = m_inpkt ? m_flowl : fin;
    e   = bus_a.i_eop;
    d   = bus_a.i_data;
    rdy = bus_a.i_ready;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (acc && r[j]) begin
          m_vld[j] = 1'b1; m_data[j] = d; m_flow[j] = fl; m_eop[j] = e;
        end else if (m_vld[j] && rdy[j]) begin
          m_vld[j] = 1'b0;
        end
      end
      if (acc) begin
        if (!m_inpkt) begin
          if (!e) begin m_inpkt = 1'b1; m_mask = r; m_flowl = fin; end
        end else if (e) begin
          m_inpkt = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    total++; if (bus_a.o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_hi got=%b exp=0", bus_a.o_ready); end
    total++; if (bus_a.o_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", bus_a.o_valid); end
    total++; if (bus_a.o_drop !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b exp=0", bus_a.o_drop); end
    step();
    reset = 1'b0; #1;
    total++; if (bus_a.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_lo got=%b exp=1", bus_a.o_ready); end
    total++; if (bus_b.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_b got=%b exp=1", bus_b.o_ready); end
    total++; if (bus_a.o_valid !== 2'b00) begin bad++; $display("FAIL rst_valid_post got=%b exp=00", bus_a.o_valid); end
    step();
  endtask

  task automatic test_single();
    drive_a(1'b1, 2'd0, 1'b1, 16'hA5A5, 2'b11);
    step();
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    total++; if (bus_a.o_valid !== 2'b01) begin bad++; $display("FAIL single_valid got=%b exp=01", bus_a.o_valid); end
    total++;
    if ({bus_a.o_data[15:0], bus_a.o_flow_id[1:0], bus_a.o_eop[0]} !== {16'hA5A5, 2'd0, 1'b1}) begin
      bad++; $display("FAIL single_beat got=%h/%0d/%b exp=a5a5/0/1",
                      bus_a.o_data[15:0], bus_a.o_flow_id[1:0], bus_a.o_eop[0]);
    end
    step();
    total++; if (bus_a.o_valid !== 2'b00) begin bad++; $display("FAIL single_drain got=%b exp=00", bus_a.o_valid); end
  endtask

  task automatic test_multi_beat();
    logic [1:0] fl [3] = '{2'd2, 2'd0, 2'd2};
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b1, fl[k], (k == 2), 16'(k + 1), 2'b11);
      step();
      total++; if (bus_a.o_valid !== 2'b10) begin bad++; $display("FAIL pkt_valid beat=%0d got=%b exp=10", k, bus_a.o_valid); end
      total++;
      if ({bus_a.o_data[31:16], bus_a.o_flow_id[3:2], bus_a.o_eop[1]} !== {16'(k + 1), 2'd2, (k == 2)}) begin
        bad++; $display("FAIL pkt_beat beat=%0d got=%h/%0d/%b exp=%h/2/%b", k,
                        bus_a.o_data[31:16], bus_a.o_flow_id[3:2], bus_a.o_eop[1], 16'(k + 1), (k == 2));
      end
    end
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    step();
    total++; if (bus_a.o_valid !== 2'b00) begin bad++; $display("FAIL pkt_drain got=%b exp=00", bus_a.o_valid); end
  endtask

  task automatic test_backpressure();
    drive_a(1'b1, 2'd2, 1'b1, 16'h0077, 2'b01);
    step();
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b1, 2'd0, 1'b1, 16'(16'h10 + k), 2'b01);
      #1;
      total++; if (bus_a.o_ready !== 1'b1) begin bad++; $display("FAIL bp_p0_ready k=%0d got=%b exp=1", k, bus_a.o_ready); end
      step();
      total++;
      if ({bus_a.o_valid, bus_a.o_data[15:0], bus_a.o_data[31:16]} !== {2'b11, 16'(16'h10 + k), 16'h0077}) begin
        bad++; $display("FAIL bp_stream k=%0d got=%b/%h/%h exp=11/%h/0077", k,
                        bus_a.o_valid, bus_a.o_data[15:0], bus_a.o_data[31:16], 16'(16'h10 + k));
      end
    end
    drive_a(1'b1, 2'd2, 1'b1, 16'h0088, 2'b01);
    #1;
    total++; if (bus_a.o_ready !== 1'b0) begin bad++; $display("FAIL bp_stall0 got=%b exp=0", bus_a.o_ready); end
    step();
    total++; if (bus_a.o_valid !== 2'b10) begin bad++; $display("FAIL bp_hold_valid got=%b exp=10", bus_a.o_valid); end
    total++; if (bus_a.o_data[31:16] !== 16'h0077) begin bad++; $display("FAIL bp_hold_data got=%h exp=0077", bus_a.o_data[31:16]); end
    #1;
    total++; if (bus_a.o_ready !== 1'b0) begin bad++; $display("FAIL bp_stall1 got=%b exp=0", bus_a.o_ready); end
    bus_a.i_ready = 2'b11;
    #1;
    total++; if (bus_a.o_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", bus_a.o_ready); end
    step();
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    total++;
    if ({bus_a.o_valid, bus_a.o_data[31:16]} !== {2'b10, 16'h0088}) begin
      bad++; $display("FAIL bp_after got=%b/%h exp=10/0088", bus_a.o_valid, bus_a.o_data[31:16]);
    end
    step();
  endtask

  task automatic test_unroutable();
    drive_a(1'b1, 2'd3, 1'b0, 16'h0005, 2'b11);
    #1;
    total++; if ({bus_a.o_ready, bus_a.o_drop} !== 2'b11) begin bad++; $display("FAIL drop_first got=%b exp=11", {bus_a.o_ready, bus_a.o_drop}); end
    step();
    total++; if (bus_a.o_valid !== 2'b00) begin bad++; $display("FAIL drop_valid1 got=%b exp=00", bus_a.o_valid); end
    drive_a(1'b1, 2'd0, 1'b1, 16'h0006, 2'b11);
    #1;
    total++; if ({bus_a.o_ready, bus_a.o_drop} !== 2'b10) begin bad++; $display("FAIL drop_second got=%b exp=10", {bus_a.o_ready, bus_a.o_drop}); end
    step();
    total++; if (bus_a.o_valid !== 2'b00) begin bad++; $display("FAIL drop_valid2 got=%b exp=00", bus_a.o_valid); end
    drive_a(1'b1, 2'd0, 1'b1, 16'h0009, 2'b11);
    #1;
    total++; if (bus_a.o_drop !== 1'b0) begin bad++; $display("FAIL drop_next got=%b exp=0", bus_a.o_drop); end
    step();
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    total++;
    if ({bus_a.o_valid, bus_a.o_data[15:0]} !== {2'b01, 16'h0009}) begin
      bad++; $display("FAIL drop_route got=%b/%h exp=01/0009", bus_a.o_valid, bus_a.o_data[15:0]);
    end
    step();
  endtask

  task automatic test_multicast();
    drive_b(1'b1, 2'd2, 1'b1, 16'h0BEE, 2'b01);
    step();
    total++; if (bus_b.o_valid !== 2'b11) begin bad++; $display("FAIL mc_fill got=%b exp=11", bus_b.o_valid); end
    drive_b(1'b1, 2'd2, 1'b1, 16'h1234, 2'b01);
    #1;
    total++; if (bus_b.o_ready !== 1'b0) begin bad++; $display("FAIL mc_stall0 got=%b exp=0", bus_b.o_ready); end
    step();
    total++; if (bus_b.o_valid !== 2'b10) begin bad++; $display("FAIL mc_partial got=%b exp=10", bus_b.o_valid); end
    #1;
    total++; if (bus_b.o_ready !== 1'b0) begin bad++; $display("FAIL mc_stall1 got=%b exp=0", bus_b.o_ready); end
    bus_b.i_ready = 2'b11;
    #1;
    total++; if (bus_b.o_ready !== 1'b1) begin bad++; $display("FAIL mc_release got=%b exp=1", bus_b.o_ready); end
    step();
    drive_b(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    total++;
    if ({bus_b.o_valid, bus_b.o_data} !== {2'b11, 16'h1234, 16'h1234}) begin
      bad++; $display("FAIL mc_both got=%b/%h exp=11/12341234", bus_b.o_valid, bus_b.o_data);
    end
    step();
    total++; if (bus_b.o_valid !== 2'b00) begin bad++; $display("FAIL mc_drain got=%b exp=00", bus_b.o_valid); end
  endtask

  task automatic test_reset_midpkt();
    drive_a(1'b1, 2'd2, 1'b0, 16'h00AA, 2'b11);
    step();
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    reset = 1'b1;
    step();
    total++; if (bus_a.o_valid !== 2'b00) begin bad++; $display("FAIL midrst_valid got=%b exp=00", bus_a.o_valid); end
    reset = 1'b0;
    drive_a(1'b1, 2'd0, 1'b1, 16'h00BB, 2'b11);
    #1;
    total++; if ({bus_a.o_ready, bus_a.o_drop} !== 2'b10) begin bad++; $display("FAIL midrst_acc got=%b exp=10", {bus_a.o_ready, bus_a.o_drop}); end
    step();
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    total++;
    if ({bus_a.o_valid, bus_a.o_data[15:0]} !== {2'b01, 16'h00BB}) begin
      bad++; $display("FAIL midrst_route got=%b/%h exp=01/00bb", bus_a.o_valid, bus_a.o_data[15:0]);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive_a($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
              16'($urandom), 2'($urandom_range(0, 3)));
      #1;
      total++;
      if (bus_a.o_ready !== exp_ready()) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus_a.o_ready, exp_ready());
      end
      total++;
      if (bus_a.o_drop !== exp_drop()) begin
        bad++; $display("FAIL rnd_drop cyc=%0d got=%b exp=%b", c, bus_a.o_drop, exp_drop());
      end
      for (int j = 0; j < 2; j++) begin
        total++;
        if (bus_a.o_valid[j] !== m_vld[j]) begin
          bad++; $display("FAIL rnd_valid cyc=%0d port=%0d got=%b exp=%b", c, j, bus_a.o_valid[j], m_vld[j]);
        end
        if (m_vld[j]) begin
          total++;
          if ({bus_a.o_data[j*16 +: 16], bus_a.o_flow_id[j*2 +: 2], bus_a.o_eop[j]} !==
              {m_data[j], m_flow[j], m_eop[j]}) begin
            bad++; $display("FAIL rnd_beat cyc=%0d port=%0d got=%h/%0d/%b exp=%h/%0d/%b", c, j,
                            bus_a.o_data[j*16 +: 16], bus_a.o_flow_id[j*2 +: 2], bus_a.o_eop[j],
                            m_data[j], m_flow[j], m_eop[j]);
          end
        end
      end
      step();
    end
    reset = 1'b0;
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive_a(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    drive_b(1'b0, 2'd0, 1'b0, 16'h0, 2'b11);
    model_reset();
    test_reset();
    test_single();
    test_multi_beat();
    test_backpressure();
    test_unroutable();
    test_multicast();
    test_reset_midpkt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_pkt_demux.md
Name: ct_pkt_demux

Overview:
- Packet-aware, registered demultiplexer: the receive-side counterpart of ct_merge.
- Takes one merged stream carrying data, flow ID and EOP, and fans it out to NO outputs.
- The output set is looked up from the flow ID on a packet's first beat and held until its EOP beat, so packets never interleave.
- Each output has a one-entry register stage; multicast is allowed.

Parameters:
- NO, 2, number of output ports (>=1)
- WD, 16, payload data width
- WF, 2, flow ID width
- NF, 2, number of flow table entries
- FLOWS, 0, packed NF*WF flow IDs; entry k = FLOWS[k*WF +: WF]
- ENABLES, 0, packed NF*NO output masks; entry k = ENABLES[k*NO +: NO], bit j set = flow k goes to output j

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- i_data  input  WD  input payload
- i_flow_id  input  WF  input flow ID; sampled on first beat of a packet only
- i_eop  input  1  last beat of packet
- i_valid  input  1  input beat valid
- o_ready  output  1  input may be accepted this cycle
- o_data  output  NO*WD  per-output payload; port j at [j*WD +: WD]
- o_flow_id  output  NO*WF  per-output flow ID; port j at [j*WF +: WF]
- o_eop  output  NO  per-output EOP
- o_valid  output  NO  per-output valid
- i_ready  input  NO  per-output downstream ready
- o_drop  output  1  one-cycle pulse when the first beat of an unroutable packet is accepted

Behaviour:
- Reset:
  - o_valid=0, o_drop=0, FSM=IDLE, latched mask=0.
  - o_ready forced 0 while reset is high.
  - o_data, o_flow_id and o_eop hold don't-care values, but the bench must never sample them while o_valid=0.
  - Reset mid-packet abandons the packet: no further beats of it are emitted, and the next accepted beat is treated as a first beat.
- Lookup (combinational):
  - Compare i_flow_id against all NF entries; the lowest matching k gives mask = ENABLES entry k.
  - No match gives mask=0.
- Active mask: in IDLE, the lookup mask; in PKT, the latched mask. i_flow_id is ignored in PKT.
- Slot readiness: slot_free[j] = !o_valid[j] || i_ready[j].
- o_ready = &(slot_free | ~active_mask). o_ready has a combinational path from i_ready; there is no path from i_valid.
- Accept: acc = i_valid && o_ready.
- Per output j, each cycle:
  - acc && active_mask[j]: load {i_data, flow ID, i_eop} and set o_valid[j]=1. The flow ID loaded is i_flow_id in IDLE and the latched flow ID in PKT.
  - Otherwise, if o_valid[j] && i_ready[j]: clear o_valid[j].
  - Otherwise: hold.
  - Load and drain in the same cycle is allowed, giving full throughput of 1 beat/cycle per port.
- Latency: exactly 1 cycle from accept to o_valid on each target output.
- Multicast: a beat is accepted only when every masked slot is free, and all targets load in the same cycle; there are no partial deliveries.
- FSM:
  - IDLE, acc && !i_eop: latch mask and flow ID, go to PKT.
  - IDLE, acc && i_eop: single-beat packet, stay in IDLE.
  - PKT, acc && i_eop: go to IDLE.
  - Otherwise: hold state.
- Unroutable packet (mask=0 in IDLE):
  - o_ready=1; the beat is consumed and nothing is loaded.
  - o_drop=1 for that one cycle.
  - If it is not an EOP beat, enter PKT with latched mask 0, so remaining beats are silently consumed until EOP. o_drop does not pulse again.
- Outputs not in the active mask are never stalled by, and never stall, the input.

Decomposition:
- Package ct_pkg:
  - Function ct_flow_lookup(flow, FLOWS, ENABLES, NF, NO, WF) returning the mask.
  - FSM state localparams ST_IDLE / ST_PKT.
- Sub-module ct_pkt_demux_slot: one output register with valid/data/flow/eop and the load/drain/hold logic, parameterised by WD and WF; instantiated NO times via generate.

Test Plan:
All scenarios use NO=2, WD=16, WF=2, NF=2, FLOWS={2'd2,2'd0}, ENABLES={2'b10,2'b01} unless noted.
1. Reset then idle -> o_valid=2'b00, o_drop=0; o_ready=0 during reset and 1 after.
2. Single beat, flow 0, data 16'hA5A5, eop=1 -> next cycle o_valid=2'b01 with port0 data A5A5, flow 0, eop 1; port1 stays invalid.
3. 3-beat packet, flow 2 (data 1,2,3), with a flow-0 beat presented mid-packet as i_flow_id=0 on beat 2 -> all 3 beats appear only on port1, in order, carrying flow 2.
4. Port1 i_ready=0 with its slot full, flow-2 beat offered -> o_ready=0 until i_ready[1]=1. Meanwhile a flow-0 stream continues at 1 beat/cycle on port0 with i_ready[0]=1.
5. Flow 3 (unmatched), 2-beat packet -> o_drop=1 on beat 1 only, no output valid, o_ready=1 throughout; a following flow-0 beat routes normally.
6. ENABLES={2'b11,2'b01}, flow-2 beat 16'h1234 with i_ready=2'b01 and port1 full -> beat held until port1 frees, then both ports are valid with 1234 in the same cycle.
